mem_arbiter: RTL and testbench

MEM_ARBITER -- requirements
Module: mem_arbiter

---
 rtl/lc3b_types.sv | 22 ++
 rtl/arbiter_control.sv | 76 +++++++
 rtl/mem_arbiter.sv | 83 ++++++++
 tb/tb_mem_arbiter.sv | 213 +++++++++++++++++++++
 4 files changed

// File: rtl/lc3b_types.sv
// Shared LC-3b word/block types plus the memory arbiter state and grant encodings.
package lc3b_types;

  typedef logic [15:0]  lc3b_word;
  typedef logic [127:0] lc3b_block;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SERVE_I = 2'd1,
    SERVE_D = 2'd2
  } arb_state_e;

  typedef enum logic {
    GRANT_I = 1'b0,
    GRANT_D = 1'b1
  } grant_e;

  function automatic logic arb_busy(input arb_state_e s);
    return (s == SERVE_I) || (s == SERVE_D);
  endfunction

endpackage

// File: rtl/arbiter_control.sv
// Arbiter FSM: round-robin grant between I and D caches, resp decode on mem_resp.
module arbiter_control
  import lc3b_types::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       i_req,
  input  logic       d_req,
  input  logic       mem_resp,
  output arb_state_e state,
  output logic       load_i,
  output logic       load_d,
  output logic       i_resp,
  output logic       d_resp
);

  arb_state_e state_q, state_d;
  grant_e     last_grant_q, last_grant_d;

  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    load_i       = 1'b0;
    load_d       = 1'b0;
    i_resp       = 1'b0;
    d_resp       = 1'b0;
    unique case (state_q)
      IDLE: begin
        // mem_resp is ignored here; a stale pulse after an abort must not complete anything.
        if (i_req && d_req) begin
          if (last_grant_q == GRANT_D) begin
            load_i  = 1'b1;
            state_d = SERVE_I;
          end else begin
            load_d  = 1'b1;
            state_d = SERVE_D;
          end
        end else if (i_req) begin
          load_i  = 1'b1;
          state_d = SERVE_I;
        end else if (d_req) begin
          load_d  = 1'b1;
          state_d = SERVE_D;
        end
      end
      SERVE_I: begin
        if (mem_resp) begin
          i_resp       = 1'b1;
          state_d      = IDLE;
          last_grant_d = GRANT_I;
        end
      end
      SERVE_D: begin
        if (mem_resp) begin
          d_resp       = 1'b1;
          state_d      = IDLE;
          last_grant_d = GRANT_D;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      last_grant_q <= GRANT_D;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
    end
  end

  assign state = state_q;

endmodule

// File: rtl/mem_arbiter.sv
// Shares one line-granular memory port between instruction and data caches;
// the granted request is captured at grant so requester changes cannot disturb it.
module mem_arbiter
  import lc3b_types::*;
(
  input  logic      clk,
  input  logic      rst,
  input  logic      i_read,
  input  lc3b_word  i_address,
  output lc3b_block i_rdata,
  output logic      i_resp,
  input  logic      d_read,
  input  logic      d_write,
  input  lc3b_word  d_address,
  input  lc3b_block d_wdata,
  output lc3b_block d_rdata,
  output logic      d_resp,
  output logic      mem_read,
  output logic      mem_write,
  output lc3b_word  mem_address,
  output lc3b_block mem_wdata,
  input  lc3b_block mem_rdata,
  input  logic      mem_resp
);

  arb_state_e state;
  logic       load_i, load_d, busy;

  lc3b_word   addr_q,  addr_d;
  lc3b_block  wdata_q, wdata_d;
  logic       write_q, write_d;

  arbiter_control u_ctrl (
    .clk      (clk),
    .rst      (rst),
    .i_req    (i_read),
    .d_req    (d_read | d_write),
    .mem_resp (mem_resp),
    .state    (state),
    .load_i   (load_i),
    .load_d   (load_d),
    .i_resp   (i_resp),
    .d_resp   (d_resp)
  );

  always_comb begin
    addr_d  = addr_q;
    wdata_d = wdata_q;
    write_d = write_q;
    if (load_i) begin
      addr_d  = i_address;
      wdata_d = '0;
      write_d = 1'b0;
    end else if (load_d) begin
      // Write takes precedence when read and write are both raised.
      addr_d  = d_address;
      wdata_d = d_wdata;
      write_d = d_write;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      addr_q  <= '0;
      wdata_q <= '0;
      write_q <= 1'b0;
    end else begin
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      write_q <= write_d;
    end
  end

  assign busy        = arb_busy(state);
  assign mem_read    = busy & ~write_q;
  assign mem_write   = busy &  write_q;
  assign mem_address = busy ? addr_q  : '0;
  assign mem_wdata   = busy ? wdata_q : '0;

  assign i_rdata = mem_rdata;
  assign d_rdata = mem_rdata;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: single transfers, round-robin ties, reset abort.
module tb_mem_arbiter;

  logic         clk = 1'b0;
  logic         rst;
  logic         i_read, d_read, d_write, mem_resp;
  logic [15:0]  i_address, d_address, mem_address;
  logic [127:0] d_wdata, mem_rdata, i_rdata, d_rdata, mem_wdata;
  logic         i_resp, d_resp, mem_read, mem_write;

  int n_cmp = 0;
  int n_err = 0;

  localparam logic [127:0] PAT_A5 = {16{8'hA5}};
  localparam logic [127:0] PAT_W  = 128'h0123_4567_89AB_CDEF_0123_4567_89AB_CDEF;
  localparam logic [127:0] PAT_5C = {16{8'h5C}};

  always #5 clk = ~clk;

  mem_arbiter dut (
    .clk         (clk),
    .rst         (rst),
    .i_read      (i_read),
    .i_address   (i_address),
    .i_rdata     (i_rdata),
    .i_resp      (i_resp),
    .d_read      (d_read),
    .d_write     (d_write),
    .d_address   (d_address),
    .d_wdata     (d_wdata),
    .d_rdata     (d_rdata),
    .d_resp      (d_resp),
    .mem_read    (mem_read),
    .mem_write   (mem_write),
    .mem_address (mem_address),
    .mem_wdata   (mem_wdata),
    .mem_rdata   (mem_rdata),
    .mem_resp    (mem_resp)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; i_read = 1'b0; d_read = 1'b0; d_write = 1'b0; mem_resp = 1'b0;
    i_address = '0; d_address = '0; d_wdata = '0; mem_rdata = PAT_5C;
    tick(); tick();
    rst = 1'b0;
    #1;
    n_cmp++; if ({mem_read, mem_write, i_resp, d_resp} !== 4'b0000) begin n_err++;
      $display("FAIL reset.ctrl got=%b exp=0000", {mem_read, mem_write, i_resp, d_resp}); end
    n_cmp++; if (mem_address !== 16'h0) begin n_err++;
      $display("FAIL reset.mem_address got=%h exp=0000", mem_address); end
    n_cmp++; if (mem_wdata !== 128'h0) begin n_err++;
      $display("FAIL reset.mem_wdata got=%h exp=0", mem_wdata); end
    n_cmp++; if (i_rdata !== PAT_5C || d_rdata !== PAT_5C) begin n_err++;
      $display("FAIL reset.rdata_pass got=%h/%h exp=%h", i_rdata, d_rdata, PAT_5C); end
    tick();
  endtask

  task automatic test_single_i();
    i_read = 1'b1; i_address = 16'h1230;
    tick();
    i_read = 1'b0; i_address = 16'hBEEF;
    for (int c = 1; c <= 2; c++) begin
      #1;
      n_cmp++; if (mem_read !== 1'b1 || mem_write !== 1'b0 || mem_address !== 16'h1230) begin n_err++;
        $display("FAIL single_i.serve c=%0d got rd=%b wr=%b addr=%h exp rd=1 wr=0 addr=1230",
                 c, mem_read, mem_write, mem_address); end
      n_cmp++; if (i_resp !== 1'b0 || d_resp !== 1'b0) begin n_err++;
        $display("FAIL single_i.early_resp c=%0d got i=%b d=%b exp 0 0", c, i_resp, d_resp); end
      tick();
    end
    mem_resp = 1'b1; mem_rdata = PAT_A5;
    #1;
    n_cmp++; if (i_resp !== 1'b1 || d_resp !== 1'b0) begin n_err++;
      $display("FAIL single_i.resp got i=%b d=%b exp i=1 d=0", i_resp, d_resp); end
    n_cmp++; if (i_rdata !== PAT_A5) begin n_err++;
      $display("FAIL single_i.rdata got=%h exp=%h", i_rdata, PAT_A5); end
    tick();
    mem_resp = 1'b0;
    #1;
    n_cmp++; if ({mem_read, mem_write, i_resp} !== 3'b000) begin n_err++;
      $display("FAIL single_i.after got=%b exp=000", {mem_read, mem_write, i_resp}); end
    tick();
  endtask

  task automatic test_d_write();
    d_write = 1'b1; d_address = 16'h4440; d_wdata = PAT_W;
    tick();
    d_write = 1'b0; d_address = 16'hFFFF; d_wdata = PAT_5C;
    for (int c = 1; c <= 2; c++) begin
      #1;
      n_cmp++; if (mem_write !== 1'b1 || mem_read !== 1'b0 || mem_address !== 16'h4440 || mem_wdata !== PAT_W) begin
        n_err++;
        $display("FAIL d_write.hold c=%0d got wr=%b rd=%b addr=%h wdata=%h exp wr=1 rd=0 addr=4440 wdata=%h",
                 c, mem_write, mem_read, mem_address, mem_wdata, PAT_W); end
      tick();
    end
    mem_resp = 1'b1;
    #1;
    n_cmp++; if (d_resp !== 1'b1 || i_resp !== 1'b0) begin n_err++;
      $display("FAIL d_write.resp got d=%b i=%b exp d=1 i=0", d_resp, i_resp); end
    tick();
    mem_resp = 1'b0;
    #1;
    n_cmp++; if ({mem_read, mem_write, d_resp} !== 3'b000) begin n_err++;
      $display("FAIL d_write.after got=%b exp=000", {mem_read, mem_write, d_resp}); end
    tick();
  endtask

  task automatic test_tie();
    logic exp_i;
    rst = 1'b1; tick(); rst = 1'b0;
    i_read = 1'b1; i_address = 16'h1111;
    d_read = 1'b1; d_address = 16'h2222;
    tick();
    for (int k = 0; k < 4; k++) begin
      exp_i = ((k % 2) == 0);
      #1;
      n_cmp++; if (mem_read !== 1'b1 || mem_address !== (exp_i ? 16'h1111 : 16'h2222)) begin n_err++;
        $display("FAIL tie.grant k=%0d got rd=%b addr=%h exp rd=1 addr=%h",
                 k, mem_read, mem_address, exp_i ? 16'h1111 : 16'h2222); end
      mem_resp = 1'b1;
      #1;
      n_cmp++; if (i_resp !== exp_i || d_resp !== ~exp_i) begin n_err++;
        $display("FAIL tie.resp k=%0d got i=%b d=%b exp i=%b d=%b", k, i_resp, d_resp, exp_i, ~exp_i); end
      tick();
      mem_resp = 1'b0;
      #1;
      n_cmp++; if ({mem_read, mem_write, i_resp, d_resp} !== 4'b0000) begin n_err++;
        $display("FAIL tie.idle k=%0d got=%b exp=0000", k, {mem_read, mem_write, i_resp, d_resp}); end
      if (k == 3) begin
        i_read = 1'b0; d_read = 1'b0;
      end
      tick();
    end
    #1;
    n_cmp++; if ({mem_read, mem_write} !== 2'b00) begin n_err++;
      $display("FAIL tie.drained got=%b exp=00", {mem_read, mem_write}); end
    tick();
  endtask

  task automatic test_reset_abort();
    d_read = 1'b1; d_address = 16'h0777;
    tick();
    d_read = 1'b0;
    #1;
    n_cmp++; if (mem_read !== 1'b1 || mem_address !== 16'h0777) begin n_err++;
      $display("FAIL abort.serve got rd=%b addr=%h exp rd=1 addr=0777", mem_read, mem_address); end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    #1;
    n_cmp++; if ({mem_read, mem_write, i_resp, d_resp} !== 4'b0000) begin n_err++;
      $display("FAIL abort.after_rst got=%b exp=0000", {mem_read, mem_write, i_resp, d_resp}); end
    tick();
    mem_resp = 1'b1;
    #1;
    n_cmp++; if (d_resp !== 1'b0 || i_resp !== 1'b0) begin n_err++;
      $display("FAIL abort.stale_resp got d=%b i=%b exp 0 0", d_resp, i_resp); end
    tick();
    mem_resp = 1'b0;
    #1;
    n_cmp++; if ({mem_read, mem_write} !== 2'b00) begin n_err++;
      $display("FAIL abort.idle got=%b exp=00", {mem_read, mem_write}); end
    tick();
  endtask

  task automatic test_rw_both();
    d_read = 1'b1; d_write = 1'b1; d_address = 16'h0008; d_wdata = PAT_A5;
    tick();
    d_read = 1'b0; d_write = 1'b0;
    #1;
    n_cmp++; if (mem_write !== 1'b1 || mem_read !== 1'b0 || mem_address !== 16'h0008) begin n_err++;
      $display("FAIL rw_both.op got wr=%b rd=%b addr=%h exp wr=1 rd=0 addr=0008",
               mem_write, mem_read, mem_address); end
    mem_resp = 1'b1;
    #1;
    n_cmp++; if (d_resp !== 1'b1) begin n_err++;
      $display("FAIL rw_both.resp got=%b exp=1", d_resp); end
    tick();
    #1;
    n_cmp++; if (d_resp !== 1'b0 || i_resp !== 1'b0) begin n_err++;
      $display("FAIL rw_both.idle_resp got d=%b i=%b exp 0 0", d_resp, i_resp); end
    tick();
    mem_resp = 1'b0;
    #1;
    n_cmp++; if ({mem_read, mem_write} !== 2'b00) begin n_err++;
      $display("FAIL rw_both.no_start got=%b exp=00", {mem_read, mem_write}); end
    tick();
  endtask

  initial begin
    test_reset();
    test_single_i();
    test_d_write();
    test_tie();
    test_reset_abort();
    test_rw_both();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout got=running exp=finished");
    $fatal(1, "timeout");
  end

endmodule
